// File: rtl/ysyx_23060025_ifu_fetch_queue_pkg.sv
// ============================================================================
// Module  : ysyx_23060025_ifu_fetch_queue_pkg
// Brief   : Shared constants and FSM encoding for the IFU fetch queue.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_23060025_ifu_fetch_queue_pkg;

  localparam int          FS_TO_DS_DATA_BUS  = 64;
  localparam logic [31:0] PC_RESET_VAL_SUB_4 = 32'h1BFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fs_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060025_ifu_fetch_queue_ibuf.sv
// ============================================================================
// Module  : ysyx_23060025_ifu_fetch_queue_ibuf
// Brief   : Synchronous power-of-2 FIFO with clear; caller never pops when
//           empty nor pushes when full without a simultaneous pop.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_23060025_ifu_fetch_queue_ibuf #(
  parameter  int DW    = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_23060025_ifu_fetch_queue.sv
// ============================================================================
// Module  : ysyx_23060025_ifu_fetch_queue
// Brief   : Fetch stage with one outstanding icache request and an {inst,pc}
//           queue toward IDU. Macro IFU_IBUF_BYPASS_EN enables 0-cycle bypass.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_23060025_ifu_fetch_queue
  import ysyx_23060025_ifu_fetch_queue_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    IBUF_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC_M4 = ADDR_WIDTH'(PC_RESET_VAL_SUB_4)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             bpu_valid_i,
  input  logic [ADDR_WIDTH-1:0]            bpu_pc_predict_i,
  input  logic                             jmp_flag_i,
  input  logic [ADDR_WIDTH-1:0]            jmp_target_i,
  input  logic                             csr_jmp_i,
  input  logic [ADDR_WIDTH-1:0]            csr_pc_i,
  input  logic                             idu_flush_i,
  input  logic [ADDR_WIDTH-1:0]            idu_flush_pc_i,
  input  logic                             ds_allowin_i,
  output logic                             fs_to_ds_valid_o,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] if_to_id_bqu_bus_o,
  output logic                             out_psel,
  output logic [ADDR_WIDTH-1:0]            out_paddr,
  input  logic                             out_pready,
  input  logic [DATA_WIDTH-1:0]            out_prdata
);

  localparam int BUS_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int CNT_W = $clog2(IBUF_DEPTH) + 1;

  fs_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic                  pend_q, pend_d;

  logic                  redir;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic [ADDR_WIDTH-1:0] nextpc;
  logic                  resp_ok;
  logic [BUS_W-1:0]      resp_bus;
  logic                  ibuf_push, ibuf_push_ok, ibuf_pop;
  logic                  ibuf_full, ibuf_empty;
  logic [CNT_W-1:0]      ibuf_count, cnt_after;
  logic [BUS_W-1:0]      ibuf_rdata;
  logic                  issue_ok;

  always_comb begin
    redir_pc = jmp_target_i;
    if (csr_jmp_i)   redir_pc = csr_pc_i;
    if (idu_flush_i) redir_pc = idu_flush_pc_i;
  end

  assign redir    = idu_flush_i | csr_jmp_i | jmp_flag_i;
  // A held target (from reset or an idle-time redirect) beats the prediction.
  assign nextpc   = redir ? redir_pc : (pend_q ? tgt_q : bpu_pc_predict_i);
  assign resp_ok  = (state_q == S_WAIT) & out_pready & ~redir;
  assign resp_bus = {out_prdata, paddr_q};
  assign ibuf_pop = ~ibuf_empty & ds_allowin_i;

`ifdef IFU_IBUF_BYPASS_EN
  logic bypass;
  assign bypass             = resp_ok & ibuf_empty;
  assign fs_to_ds_valid_o   = ~ibuf_empty | bypass;
  assign if_to_id_bqu_bus_o = ibuf_empty ? resp_bus : ibuf_rdata;
  assign ibuf_push          = resp_ok & ~(bypass & ds_allowin_i);
`else
  assign fs_to_ds_valid_o   = ~ibuf_empty;
  assign if_to_id_bqu_bus_o = ibuf_rdata;
  assign ibuf_push          = resp_ok;
`endif

  assign ibuf_push_ok = ibuf_push & (~ibuf_full | ibuf_pop);
  // Occupancy after this cycle; a new request needs a free slot for its reply.
  assign cnt_after    = redir ? '0 : ibuf_count + CNT_W'(ibuf_push_ok) - CNT_W'(ibuf_pop);
  assign issue_ok     = bpu_valid_i & (cnt_after < CNT_W'(IBUF_DEPTH));

  ysyx_23060025_ifu_fetch_queue_ibuf #(
    .DW    (BUS_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clock   (clock),
    .reset   (reset),
    .push_i  (ibuf_push_ok),
    .pop_i   (ibuf_pop),
    .clear_i (redir),
    .wdata_i (resp_bus),
    .rdata_o (ibuf_rdata),
    .full_o  (ibuf_full),
    .empty_o (ibuf_empty),
    .count_o (ibuf_count)
  );

  always_comb begin
    state_d = state_q;
    paddr_d = paddr_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (issue_ok) begin
          paddr_d = nextpc;
          pend_d  = 1'b0;
          state_d = S_WAIT;
        end else if (redir) begin
          tgt_d  = redir_pc;
          pend_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (out_pready) begin
          if (redir) begin
            paddr_d = redir_pc;
            pend_d  = 1'b0;
          end else if (issue_ok) begin
            paddr_d = nextpc;
            pend_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (redir) begin
          tgt_d   = redir_pc;
          pend_d  = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The stale reply is dropped; the redirect target goes out right away.
        if (out_pready) begin
          paddr_d = redir ? redir_pc : tgt_q;
          pend_d  = 1'b0;
          state_d = S_WAIT;
        end else if (redir) begin
          tgt_d = redir_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      paddr_q <= RESET_PC_M4;
      tgt_q   <= RESET_PC_M4 + ADDR_WIDTH'(4);
      pend_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
    end
  end

  assign out_psel  = (state_q != S_IDLE);
  assign out_paddr = paddr_q;

endmodule

`default_nettype wire
